// File: rtl/mips_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_sim_pkg
// Description : Shared types and constants for the MIPS simulation harness.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_sim_pkg;

    localparam int          CNT_W        = 32;
    localparam logic [31:0] SYSCALL_CODE = 32'h0000000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear and enable, holding at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import mips_sim_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Holds the core in reset, releases it on start, gates it with
//               cpu_run and stops it on syscall, self-loop or cycle budget.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import mips_sim_pkg::*;
#(
    parameter int          MAX_CYCLES = 1024,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] HALT_CODE  = SYSCALL_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] code,
    output logic        cpu_rst,
    output logic        cpu_run,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycles,
    output logic [31:0] instret,
    output logic [31:0] halt_pc
);

    run_state_t  r_state;
    run_state_t  w_next_state;
    logic        r_start;
    logic [3:0]  r_hold;
    logic [31:0] r_prev_pc;
    logic        r_first;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_halt_pc;

    logic        w_idle_or_done;
    logic        w_restart;
    logic        w_in_run;
    logic        w_self_loop;
    logic        w_halt;
    logic        w_budget;
    logic        w_term;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_restart      = w_idle_or_done && r_start;
    assign w_in_run       = (r_state == ST_RUN);
    assign w_self_loop    = !r_first && (pc == r_prev_pc);
    assign w_halt         = w_in_run && ((code == HALT_CODE) || w_self_loop);
    assign w_budget       = w_in_run && (({1'b0, cycles} + 33'd1) == 33'(MAX_CYCLES));
    assign w_term         = w_halt || w_budget;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cpu_rst      = 1'b1;
        cpu_run      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_start) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold == 4'd1) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst = 1'b0;
                cpu_run = 1'b1;
                if (w_term) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                cpu_rst = 1'b0;
                if (r_start) w_next_state = ST_HOLD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // start is registered first, and only while a new run may be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= 1'b0;
            r_hold  <= 4'd0;
        end else begin
            r_start <= start && w_idle_or_done;
            if (w_restart) begin
                r_hold <= 4'(RST_CYCLES);
            end else if ((r_state == ST_HOLD) && (r_hold != 4'd0)) begin
                r_hold <= r_hold - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_pc <= 32'd0;
            r_first   <= 1'b1;
        end else if (w_restart) begin
            r_first   <= 1'b1;
        end else if (w_in_run) begin
            r_prev_pc <= pc;
            r_first   <= 1'b0;
        end
    end

    // halt wins over the budget when both occur on the same cycle
    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_halt_pc <= 32'd0;
        end else if (w_in_run && w_term) begin
            r_done    <= 1'b1;
            r_timeout <= !w_halt;
            r_halt_pc <= pc;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_restart),
        .en    (w_in_run),
        .count (cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instret (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_restart),
        .en    (w_in_run && !w_term),
        .count (instret)
    );

    assign done    = r_done;
    assign timeout = r_timeout;
    assign halt_pc = r_halt_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl against a run-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int          MAXC = 16;
    localparam int          RSTC = 2;
    localparam logic [31:0] HALT = 32'h0000000C;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] pc, code;
    logic        cpu_rst, cpu_run, done, timeout;
    logic [31:0] cycles, instret, halt_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_code[$];
    logic        exp_valid, exp_to;
    logic [31:0] exp_cycles, exp_instret, exp_halt_pc;

    cpu_run_ctrl #(.MAX_CYCLES(MAXC), .RST_CYCLES(RSTC), .HALT_CODE(HALT)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .code(code),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .done(done), .timeout(timeout),
        .cycles(cycles), .instret(instret), .halt_pc(halt_pc)
    );

    always #5 clk = ~clk;

    // Walks the per-cycle program trace and finds the first terminating cycle.
    function automatic void model();
        exp_valid = 1'b0;
        for (int k = 1; k <= q_pc.size(); k++) begin
            logic h, t;
            h = (q_code[k-1] == HALT) || (k > 1 && q_pc[k-1] == q_pc[k-2]);
            t = (k == MAXC);
            if ((h || t) && !exp_valid) begin
                exp_valid   = 1'b1;
                exp_cycles  = k;
                exp_instret = k - 1;
                exp_halt_pc = q_pc[k-1];
                exp_to      = !h;
            end
        end
    endfunction

    task automatic run_prog(input string name, input bit poke_start);
        int lat, k;
        logic [99:0] got, want;
        model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (!cpu_run && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) begin
                checks++;
                if ({cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc} !==
                    {1'b1, 1'b0, 1'b0, 1'b0, 96'd0}) begin
                    errors++;
                    $display("FAIL %s hold_clear: rst=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d hpc=%h, need 1 0 0 0 0 0 0",
                             name, cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc);
                end
            end
        end
        checks++;
        if (lat !== RSTC + 1) begin
            errors++;
            $display("FAIL %s run_latency: got %0d need %0d", name, lat, RSTC + 1);
        end
        k = 0;
        while (cpu_run && k < q_pc.size()) begin
            pc    = q_pc[k];
            code  = q_code[k];
            start = poke_start && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1; k++;
        end
        start = 1'b0;
        want = {1'b0, 1'b0, 1'b1, exp_to, exp_cycles, exp_instret, exp_halt_pc};
        for (int r = 0; r < 2; r++) begin
            got = {cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s result%0d: rst=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d hpc=%h, need 0 0 1 %0b %0d %0d %h",
                         name, r, cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc,
                         exp_to, exp_cycles, exp_instret, exp_halt_pc);
            end
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_linear(input logic [31:0] base, input logic [31:0] op);
        q_pc.delete(); q_code.delete();
        for (int i = 0; i < MAXC; i++) begin
            q_pc.push_back(base + 32'(4 * i));
            q_code.push_back(op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pc = 32'd0; code = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 96'd0}) begin
                errors++;
                $display("FAIL reset_idle%0d: rst=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d hpc=%h, need 1 0 0 0 0 0 0",
                         i, cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc);
            end
        end
    endtask

    task automatic test_syscall();
        fill_linear(32'd0, 32'h00000020);
        q_code[5] = HALT;
        run_prog("syscall", 1'b0);
    endtask

    task automatic test_self_loop();
        fill_linear(32'd0, 32'h00000020);
        q_pc[3] = 32'h8;
        for (int i = 4; i < MAXC; i++) q_pc[i] = 32'h8 + 32'(4 * i);
        run_prog("self_loop", 1'b0);
    endtask

    task automatic test_timeout();
        fill_linear(32'h00400000, 32'h00000000);
        run_prog("timeout", 1'b0);
    endtask

    task automatic test_simultaneous();
        fill_linear(32'h00001000, 32'h01234567);
        q_code[MAXC-1] = HALT;
        run_prog("simultaneous", 1'b0);
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (!cpu_run && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        for (int i = 0; i < 4; i++) begin
            pc = 32'(4 * i); code = 32'h00000020;
            start = (i == 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if ({cpu_run, done, cycles, instret} !== {1'b1, 1'b0, 32'd4, 32'd4}) begin
            errors++;
            $display("FAIL mid_run_progress: run=%0b done=%0b cyc=%0d ret=%0d, need 1 0 4 4",
                     cpu_run, done, cycles, instret);
        end
        pc = 32'd16; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 96'd0}) begin
                errors++;
                $display("FAIL mid_reset%0d: rst=%0b run=%0b done=%0b to=%0b cyc=%0d ret=%0d hpc=%h, need 1 0 0 0 0 0 0",
                         i, cpu_rst, cpu_run, done, timeout, cycles, instret, halt_pc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        for (int n = 0; n < 8; n++) begin
            q_pc.delete(); q_code.delete();
            p = {$urandom_range(0, 32'hFFFF), 2'b00};
            for (int i = 0; i < MAXC; i++) begin
                int r;
                r = $urandom_range(0, 11);
                if (i > 0 && r == 0)      p = p;
                else if (i > 0 && r == 1) p = {$urandom_range(0, 32'hFFFF), 2'b00};
                else if (i > 0)           p = p + 32'd4;
                q_pc.push_back(p);
                q_code.push_back(($urandom_range(0, 13) == 0) ? HALT : $urandom());
            end
            run_prog($sformatf("random%0d", n), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_self_loop();
        test_timeout();
        test_simultaneous();
        test_mid_reset();
        test_syscall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller on the CPU side of the simulation harness. It holds the single-cycle MIPS core in reset, releases it on `start`, and gates execution with `cpu_run`. While running it counts cycles and retired instructions, detects program termination from the fetched instruction stream, and reports `done`/`timeout` with the final PC. The core is then stopped by its own termination condition instead of by a fixed externally counted cycle budget.

## Interface
Parameters:
- `MAX_CYCLES`, 1024: RUN-cycle budget; reaching it ends the run with `timeout`.
- `RST_CYCLES`, 2: cycles `cpu_rst` is held high before RUN; legal range 1..15.
- `HALT_CODE`, 32'h0000000C: instruction word (`syscall`) that terminates the run.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled request to begin a run.
- `pc` in 32: core's current PC.
- `code` in 32: instruction word fetched at `pc`.
- `cpu_rst` out 1: reset to the core.
- `cpu_run` out 1: core clock-enable; PC and register file update only while high.
- `done` out 1: run finished, sticky until the next start or `rst`.
- `timeout` out 1: run ended on the cycle budget, valid with `done`.
- `cycles` out 32: RUN cycles elapsed.
- `instret` out 32: instructions retired.
- `halt_pc` out 32: PC at termination.

## Operation
- States: IDLE, HOLD, RUN, DONE.
- IDLE: `cpu_rst`=1, `cpu_run`=0. `start`=1 -> HOLD; clear `cycles`, `instret`, `halt_pc`, `done`, `timeout`; load the hold counter with `RST_CYCLES`.
- HOLD: `cpu_rst`=1, `cpu_run`=0; decrement the hold counter; when it is 1 -> RUN.
- RUN: `cpu_rst`=0, `cpu_run`=1; `cycles` increments every cycle.
- A RUN cycle retires an instruction unless it is a termination cycle.
- Termination, evaluated every RUN cycle:
  - halt: `code`==`HALT_CODE`, or self-loop, meaning `pc` equals the previous RUN cycle's `pc`. The self-loop check is inactive on the first RUN cycle.
  - timeout: `cycles`+1 == `MAX_CYCLES` on this cycle.
  - On either condition: -> DONE, latch `halt_pc`=`pc`, set `done`=1. `timeout`=1 only if no halt condition holds in the same cycle, so halt has priority.
  - The terminating cycle still counts in `cycles`, but not in `instret`.
- DONE: `cpu_run`=0, `cpu_rst`=0, so the core state stays inspectable. All outputs hold. `start`=1 -> HOLD with counters cleared.
- `start` is ignored in HOLD and RUN.
- Counters saturate at 32'hFFFFFFFF and never wrap.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `cpu_run`=0, `done`=0, `timeout`=0, `cycles`=0, `instret`=0, `halt_pc`=0.
- `rst` has priority over every other input in every state. A reset during RUN returns to IDLE on the next edge; counters clear and nothing is latched.
- Registered Moore outputs only; no combinational path from inputs to outputs.
- `start` sampled at edge N -> HOLD from N+1; `cpu_run` rises at edge N+1+`RST_CYCLES`.
- Terminating condition present during the cycle before edge M -> `done`, `halt_pc` and `timeout` valid and `cpu_run`=0 after edge M (1-cycle latency).
- Self-loop detection needs one registered `prev_pc`, updated only in RUN.

## Structure
- Shared package `mips_sim_pkg`:
  - state enum `run_state_t`
  - constant `SYSCALL_CODE` = 32'h0000000C
  - counter width constant `CNT_W` = 32
- One sub-module: `sat_counter`, a saturating up-counter with clear and enable, instanced for `cycles` and `instret`.
- FSM, hold counter, `prev_pc` and latches stay in `cpu_run_ctrl`.
- Target size is roughly 150–250 lines of RTL.

## Test plan
- Reset/idle: assert `rst` 3 cycles, `start`=0 -> `cpu_rst`=1, `cpu_run`=0, all counters 0 for 20 cycles.
- Syscall halt: `start` pulse; PC advances by 4 from 0. At `pc`=0x14 drive `code`=0x0000000C -> `done`=1, `timeout`=0, `halt_pc`=0x14, `cycles`=6, `instret`=5; `cpu_run` rises exactly `RST_CYCLES`+1 cycles after `start`.
- Self-loop halt: PC 0,4,8,8 -> `done`, `halt_pc`=0x8, `cycles`=4, `instret`=3.
- Timeout: `MAX_CYCLES`=16, PC always increments -> `done`=1, `timeout`=1, `cycles`=16, `instret`=15.
- Simultaneous: `code`=HALT_CODE on the 16th cycle with `MAX_CYCLES`=16 -> `timeout`=0, `done`=1.
- Mid-run reset and restart: `rst` at cycle 5 of RUN -> IDLE, counters 0. A new `start` runs again; `start` pulses during RUN are ignored, and `start` in DONE restarts with cleared counters.
